airlock_timer_ctrl: RTL and testbench
=====================================

// Module: airlock_timer_ctrl
// PURPOSE
//   Shared countdown-timer controller for the airlock interlock FSM. It accepts
//   the interlock's wait_start/fill_start/drain_start level requests and runs
//   one prescaled minute counter. It returns wait_done/fill_done/drain_done
//   after 5/7/8 minutes. Sits beside the interlock on the same clk; one
//   counter is time-shared between the three phases.
// PARAMETERS
//   TICK_DIV   50  clk cycles per "minute" tick (>=2; board builds override)
//   WAIT_MIN   5   wait-phase duration in minutes (1..15)
//   FILL_MIN   7   fill-phase duration in minutes (1..15)
//   DRAIN_MIN  8   drain-phase duration in minutes (1..15)
// PORTS
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high reset
//   wait_start   in   1  level request for the wait timer (held until done seen)
//   fill_start   in   1  level request for the fill timer
//   drain_start  in   1  level request for the drain timer
//   wait_done    out  1  high from expiry until wait_start drops
//   fill_done    out  1  high from expiry until fill_start drops
//   drain_done   out  1  high from expiry until drain_start drops
//   busy         out  1  high in RUN or DONE
//   remain_min   out  4  minutes left, rounded up; present only with TIMER_REMAIN_OUT_EN
// BEHAVIOUR
//   - Clock/reset: one clock, clk. reset is synchronous and active-high.
//   - Reset values: state=IDLE, sel=NONE, all *_done=0, busy=0, tick_cnt=0,
//     min_cnt=0. A reset mid-count aborts the count. No done pulse follows.
//   - States: IDLE, RUN, DONE. All outputs are registered.
//   - IDLE: if any start is high at an edge, go to RUN on that edge.
//     Priority is drain > fill > wait. Latch the winner as sel.
//     Load min_cnt with that phase's duration and clear tick_cnt.
//   - RUN: tick_cnt counts 0..TICK_DIV-1 and wraps. On each wrap min_cnt
//     decrements. On the wrap where min_cnt==1, go to DONE and raise sel's
//     *_done. Done is visible exactly dur*TICK_DIV edges after the IDLE->RUN
//     edge.
//   - RUN abort: if sel's start is low at any edge, return to IDLE and clear
//     the counters. No done is raised. Abort wins over a same-cycle expiry.
//   - DONE: hold sel's done high. When sel's start is low, go to IDLE and drop
//     done on that edge.
//   - Non-selected starts are ignored while busy. They are sampled again in
//     IDLE, so a back-to-back request costs one IDLE cycle.
//   - At most one *_done is ever high. No done is ever high outside DONE.
//   - Width rules: min_cnt is 4 bits. tick_cnt is $clog2(TICK_DIV) bits.
//     Both are unsigned. Neither wraps below zero.
// CONFIGURATION
//   TIMER_REMAIN_OUT_EN defined: the remain_min port exists.
//     - RUN: remain_min = min_cnt.
//     - IDLE and DONE: remain_min = 0.
//     - Drives the board HEX display.
//   TIMER_REMAIN_OUT_EN undefined: no port and no extra logic. Timing is
//     identical in both builds.
// STRUCTURE
//   - airlock_pkg holds:
//     - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
//     - sel codes: NONE, WAIT, FILL, DRAIN
//     - default durations: 5, 7, 8
//   - Sub-module min_prescaler(clk, reset, clr, en, tick): the tick_cnt
//     divider. tick is a 1-cycle pulse on wrap. clr has priority over en.
//   - The controller FSM and min_cnt stay in airlock_timer_ctrl.
// TESTING (TICK_DIV=4, default durations)
//   1. Hold wait_start from cycle 0 -> wait_done rises at edge 20 (5*4) and
//      stays high. Drop start -> done low on the next edge, busy low.
//   2. Hold fill_start -> fill_done at edge 28. Hold drain_start -> drain_done
//      at edge 32. Other done outputs stay 0 throughout.
//   3. Raise wait_start and drain_start on the same edge -> drain is selected.
//      drain_done comes at 32. wait_done stays 0 until drain_start drops, then
//      1 IDLE cycle + 20 more edges.
//   4. Raise fill_start, drop it at edge 10 -> IDLE at edge 10, fill_done never
//      rises. Re-raise it -> the full 28-edge count restarts.
//   5. Pulse reset at edge 15 of a drain count -> next cycle all outputs 0 and
//      state IDLE. With start still high, drain_done comes 32 edges after the
//      restart.
//   6. With TIMER_REMAIN_OUT_EN, during wait -> remain_min steps 5,4,3,2,1 every
//      4 edges, then 0 in DONE.

Source files
------------

// File: rtl/airlock_pkg.sv
// Shared types and defaults for the airlock countdown-timer controller.
package airlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_WAIT  = 2'd1,
    SEL_FILL  = 2'd2,
    SEL_DRAIN = 2'd3
  } sel_e;

  localparam int unsigned MIN_W         = 4;
  localparam int unsigned DEF_TICK_DIV  = 50;
  localparam int unsigned DEF_WAIT_MIN  = 5;
  localparam int unsigned DEF_FILL_MIN  = 7;
  localparam int unsigned DEF_DRAIN_MIN = 8;

  // Level of the start request belonging to the latched phase.
  function automatic logic sel_start(sel_e sel, logic wait_s, logic fill_s, logic drain_s);
    logic s;
    case (sel)
      SEL_WAIT:  s = wait_s;
      SEL_FILL:  s = fill_s;
      SEL_DRAIN: s = drain_s;
      default:   s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/min_prescaler.sv
// Minute-tick divider: counts 0..TICK_DIV-1 while enabled and pulses tick on wrap.
module min_prescaler #(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] tick_cnt_q;
  logic [CNT_W-1:0] tick_cnt_d;
  logic             wrap_c;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    wrap_c     = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    if (clr) begin
      tick_cnt_d = '0;
    end else if (en) begin
      tick_cnt_d = wrap_c ? '0 : tick_cnt_q + CNT_W'(1);
    end
  end

  // Combinational so the wrap and the minute decrement share one edge.
  assign tick = en && !clr && wrap_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/airlock_timer_ctrl.sv
// Time-shared wait/fill/drain countdown timer for the airlock interlock.
// Optional remain_min display output is enabled by defining TIMER_REMAIN_OUT_EN.
module airlock_timer_ctrl
  import airlock_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned WAIT_MIN  = DEF_WAIT_MIN,
  parameter int unsigned FILL_MIN  = DEF_FILL_MIN,
  parameter int unsigned DRAIN_MIN = DEF_DRAIN_MIN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wait_start,
  input  logic             fill_start,
  input  logic             drain_start,
  output logic             wait_done,
  output logic             fill_done,
  output logic             drain_done,
  output logic             busy
`ifdef TIMER_REMAIN_OUT_EN
  ,
  output logic [MIN_W-1:0] remain_min
`endif
);

  state_e           state_q, state_d;
  sel_e             sel_q, sel_d;
  logic [MIN_W-1:0] min_cnt_q, min_cnt_d;
  logic [2:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             pre_clr, pre_en, tick;
  logic             sel_start_c;

  min_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .en    (pre_en),
    .tick  (tick)
  );

  assign sel_start_c = sel_start(sel_q, wait_start, fill_start, drain_start);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    min_cnt_d = min_cnt_q;
    pre_clr   = 1'b1;
    pre_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (drain_start) begin
          state_d   = ST_RUN;
          sel_d     = SEL_DRAIN;
          min_cnt_d = MIN_W'(DRAIN_MIN);
        end else if (fill_start) begin
          state_d   = ST_RUN;
          sel_d     = SEL_FILL;
          min_cnt_d = MIN_W'(FILL_MIN);
        end else if (wait_start) begin
          state_d   = ST_RUN;
          sel_d     = SEL_WAIT;
          min_cnt_d = MIN_W'(WAIT_MIN);
        end
      end
      ST_RUN: begin
        // A dropped request aborts even on the expiry edge.
        if (!sel_start_c) begin
          state_d   = ST_IDLE;
          sel_d     = SEL_NONE;
          min_cnt_d = '0;
        end else begin
          pre_clr = 1'b0;
          pre_en  = 1'b1;
          if (tick) begin
            min_cnt_d = (min_cnt_q != '0) ? min_cnt_q - MIN_W'(1) : '0;
            if (min_cnt_q == MIN_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (!sel_start_c) begin
          state_d   = ST_IDLE;
          sel_d     = SEL_NONE;
          min_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        sel_d     = SEL_NONE;
        min_cnt_d = '0;
      end
    endcase

    done_d = {3{state_d == ST_DONE}} &
             {sel_d == SEL_DRAIN, sel_d == SEL_FILL, sel_d == SEL_WAIT};
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= SEL_NONE;
      min_cnt_q <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      min_cnt_q <= min_cnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign wait_done  = done_q[0];
  assign fill_done  = done_q[1];
  assign drain_done = done_q[2];
  assign busy       = busy_q;

`ifdef TIMER_REMAIN_OUT_EN
  logic [MIN_W-1:0] remain_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      remain_q <= '0;
    end else begin
      remain_q <= (state_d == ST_RUN) ? min_cnt_d : '0;
    end
  end

  assign remain_min = remain_q;
`endif

endmodule

// File: tb/tb_airlock_timer_ctrl.sv
// Bench for airlock_timer_ctrl: directed scenarios plus random start/reset traffic
// against an elapsed-edge reference model.
module tb_airlock_timer_ctrl;

  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic reset, ws, fs, ds;
  logic wd, fd, dd, busy;
`ifdef TIMER_REMAIN_OUT_EN
  logic [3:0] rm;
`endif

  always #5 clk = ~clk;

  airlock_timer_ctrl #(
    .TICK_DIV  (T),
    .WAIT_MIN  (5),
    .FILL_MIN  (7),
    .DRAIN_MIN (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wait_start  (ws),
    .fill_start  (fs),
    .drain_start (ds),
    .wait_done   (wd),
    .fill_done   (fd),
    .drain_done  (dd),
    .busy        (busy)
`ifdef TIMER_REMAIN_OUT_EN
    ,
    .remain_min  (rm)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference: phase 0=idle 1=run 2=done; sel 1=wait 2=fill 3=drain; el = edges since start.
  int m_phase = 0;
  int m_sel   = 0;
  int m_el    = 0;
  int dur [4] = '{0, 5, 7, 8};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic req(input int s);
    case (s)
      1:       return ws;
      2:       return fs;
      3:       return ds;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic done_of(input int s);
    case (s)
      1:       return wd;
      2:       return fd;
      3:       return dd;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_phase = 0; m_sel = 0; m_el = 0;
    end else begin
      case (m_phase)
        0: begin
          m_sel = ds ? 3 : fs ? 2 : ws ? 1 : 0;
          if (m_sel != 0) begin m_phase = 1; m_el = 0; end
        end
        1: begin
          if (!req(m_sel)) begin m_phase = 0; m_sel = 0; end
          else begin
            m_el++;
            if (m_el == dur[m_sel] * T) m_phase = 2;
          end
        end
        default: if (!req(m_sel)) begin m_phase = 0; m_sel = 0; end
      endcase
    end
  endtask

  // One clock edge: advance the model, then compare all outputs 1 time unit later.
  task automatic step();
    int exp_rm;
    @(posedge clk);
    model_edge();
    #1;
    chk("wait_done",  32'(wd),   32'(m_phase == 2 && m_sel == 1));
    chk("fill_done",  32'(fd),   32'(m_phase == 2 && m_sel == 2));
    chk("drain_done", 32'(dd),   32'(m_phase == 2 && m_sel == 3));
    chk("busy",       32'(busy), 32'(m_phase != 0));
    chk("onehot",     32'($countones({wd, fd, dd}) <= 1), 32'd1);
    exp_rm = (m_phase == 1) ? (dur[m_sel] * T - m_el + T - 1) / T : 0;
`ifdef TIMER_REMAIN_OUT_EN
    chk("remain_min", 32'(rm), 32'(exp_rm));
`else
    if (exp_rm < 0) $display("negative remain %0d", exp_rm);
`endif
  endtask

  // Count edges, including the starting edge, until the given done output rises.
  task automatic edges_to_done(input string tag, input int s, input int exp);
    int n = 0;
    do begin
      step();
      n++;
    end while (!done_of(s) && n < 200);
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; ws = 1'b0; fs = 1'b0; ds = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'({wd, fd, dd}), 32'd0);
    reset = 1'b0;
    step();

    // Wait phase: done after 5*T edges from the IDLE->RUN edge.
    ws = 1'b1;
    edges_to_done("lat_wait", 1, 5 * T + 1);
    repeat (3) step();
    chk("wait_hold", 32'(wd), 32'd1);
    ws = 1'b0;
    step();
    chk("wait_drop", 32'({wd, busy}), 32'd0);

    fs = 1'b1;
    edges_to_done("lat_fill", 2, 7 * T + 1);
    fs = 1'b0; step();
    ds = 1'b1;
    edges_to_done("lat_drain", 3, 8 * T + 1);
    ds = 1'b0; step();

    // Drain wins over wait; wait then costs one IDLE cycle plus its full count.
    ws = 1'b1; ds = 1'b1;
    edges_to_done("prio_drain", 3, 8 * T + 1);
    repeat (4) step();
    chk("prio_wait_low", 32'(wd), 32'd0);
    ds = 1'b0;
    step();
    chk("prio_idle", 32'(busy), 32'd0);
    edges_to_done("lat_wait_b2b", 1, 5 * T + 1);
    ws = 1'b0; step();

    // Abort mid fill at edge 10, then a full restart.
    fs = 1'b1;
    repeat (10) step();
    fs = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(fd), 32'd0);
    fs = 1'b1;
    edges_to_done("lat_fill_restart", 2, 7 * T + 1);
    fs = 1'b0; step();

    // Reset at edge 15 of a drain count.
    ds = 1'b1;
    repeat (15) step();
    reset = 1'b1;
    step();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'({wd, fd, dd}), 32'd0);
    reset = 1'b0;
    edges_to_done("lat_drain_rst", 3, 8 * T + 1);
    ds = 1'b0; step();

    // Random traffic: slow-toggling starts, eager release after done, rare reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) ws = ~ws;
      if ($urandom_range(0, 39) == 0) fs = ~fs;
      if ($urandom_range(0, 39) == 0) ds = ~ds;
      if (wd && $urandom_range(0, 3) == 0) ws = 1'b0;
      if (fd && $urandom_range(0, 3) == 0) fs = 1'b0;
      if (dd && $urandom_range(0, 3) == 0) ds = 1'b0;
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; ws = 1'b0; fs = 1'b0; ds = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
